// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int INSN_BYTES = 4;

  // Width needed to hold an occupancy value from 0 to depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO of {pc, insn} entries; flush beats push, head reads zero when empty.
module ifetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] wdata_i,
  output logic         valid_o,
  output logic [W-1:0] head_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop_i & ~flush_i & (count_q != '0);
  assign do_push = push_i & ~flush_i & ((count_q != FULL) | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (srst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch engine: one outstanding word read, prefetch FIFO, redirect with
// flush of buffered and in-flight fetches.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clock,
  input  logic          reset,
  output logic          m_req,
  output logic [AW-1:0] m_addr,
  input  logic          m_ack,
  input  logic [DW-1:0] m_rdata,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          ir_valid,
  output logic [DW-1:0] ir,
  output logic [AW-1:0] ir_pc,
  input  logic          ir_ready
);

  localparam int            CW      = count_width(DEPTH);
  localparam int            FW      = AW + DW;
  localparam logic [AW-1:0] STEP    = AW'(INSN_BYTES);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

  state_e        state_q;
  logic          m_req_q;
  logic [AW-1:0] m_addr_q;
  logic [AW-1:0] next_pc_q;

  logic [AW-1:0] target_pc;
  logic [AW-1:0] addr_inc;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_valid;
  logic [CW-1:0] fifo_count;
  logic [FW-1:0] fifo_head;
  logic [CW:0]   count_after;
  logic          room_after_push;
  logic          room_now;

  assign target_pc = redirect_pc & ~AW'(3);
  assign addr_inc  = m_addr_q + STEP;

  // Redirect wins over both the pop from decode and the push of returning data.
  assign fifo_pop  = fifo_valid & ir_ready & ~redirect;
  assign fifo_push = (state_q == FETCH) & m_ack & ~redirect;

  assign count_after     = {1'b0, fifo_count} + (CW+1)'(1) - (CW+1)'(fifo_pop);
  assign room_after_push = (count_after < DEPTH_W);
  assign room_now        = ({1'b0, fifo_count} < DEPTH_W) | fifo_pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      m_req_q   <= 1'b0;
      m_addr_q  <= RESET_PC;
      next_pc_q <= RESET_PC;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect) begin
            next_pc_q <= target_pc;
            m_addr_q  <= target_pc;
            state_q   <= FETCH;
            m_req_q   <= 1'b1;
          end else if (room_now) begin
            m_addr_q <= next_pc_q;
            state_q  <= FETCH;
            m_req_q  <= 1'b1;
          end
        end
        FETCH: begin
          if (m_ack && redirect) begin
            m_addr_q  <= target_pc;
            next_pc_q <= target_pc;
          end else if (m_ack) begin
            next_pc_q <= addr_inc;
            if (room_after_push) begin
              m_addr_q <= addr_inc;
            end else begin
              state_q <= IDLE;
              m_req_q <= 1'b0;
            end
          end else if (redirect) begin
            // Address must stay on the bus until the pending ack arrives.
            next_pc_q <= target_pc;
            state_q   <= FLUSH;
          end
        end
        FLUSH: begin
          if (redirect) begin
            next_pc_q <= target_pc;
          end
          if (m_ack) begin
            m_addr_q <= redirect ? target_pc : next_pc_q;
            state_q  <= FETCH;
          end
        end
        default: begin
          state_q <= IDLE;
          m_req_q <= 1'b0;
        end
      endcase
    end
  end

  ifetch_fifo #(
    .W     (FW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clock),
    .srst    (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (redirect),
    .wdata_i ({m_addr_q, m_rdata}),
    .valid_o (fifo_valid),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  assign m_req    = m_req_q;
  assign m_addr   = m_addr_q;
  assign ir_valid = fifo_valid;
  assign ir       = fifo_head[DW-1:0];
  assign ir_pc    = fifo_head[FW-1:DW];

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: default-reset instance plus a RESET_PC=FFFFFFF8 instance.
module tb_ifetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        m_req;
  logic [31:0] m_addr;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ir_valid;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_ready;

  logic        m_req_b;
  logic [31:0] m_addr_b;
  logic        m_ack_b;
  logic [31:0] m_rdata_b;
  logic        redirect_b;
  logic [31:0] redirect_pc_b;
  logic        ir_valid_b;
  logic [31:0] ir_b;
  logic [31:0] ir_pc_b;
  logic        ir_ready_b;

  int   mem_lat;
  int   wcnt;
  int   ack_cnt;
  int   checks;
  int   errors;
  logic saw20;

  always #5 clock = ~clock;

  ifetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .m_req       (m_req),
    .m_addr      (m_addr),
    .m_ack       (m_ack),
    .m_rdata     (m_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ir_valid    (ir_valid),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_ready    (ir_ready)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clock       (clock),
    .reset       (reset),
    .m_req       (m_req_b),
    .m_addr      (m_addr_b),
    .m_ack       (m_ack_b),
    .m_rdata     (m_rdata_b),
    .redirect    (redirect_b),
    .redirect_pc (redirect_pc_b),
    .ir_valid    (ir_valid_b),
    .ir          (ir_b),
    .ir_pc       (ir_pc_b),
    .ir_ready    (ir_ready_b)
  );

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h001F_0018;
      32'h4:   return 32'h002F_0010;
      32'h8:   return 32'h003F_0014;
      32'hC:   return 32'h1322_1000;
      default: return 32'hA000_0000 ^ a;
    endcase
  endfunction

  // Memory with programmable ack latency (0 = same-cycle ack).
  assign m_ack     = m_req && (wcnt == mem_lat);
  assign m_rdata   = insn_of(m_addr);
  assign m_ack_b   = m_req_b;
  assign m_rdata_b = 32'hA000_0000 ^ m_addr_b;

  always @(posedge clock) begin
    if (reset || !m_req || m_ack) wcnt <= 0;
    else                          wcnt <= wcnt + 1;
    if (reset) begin
      ack_cnt <= 0;
      saw20   <= 1'b0;
    end else begin
      if (m_req && m_ack) ack_cnt <= ack_cnt + 1;
      if ((m_req && m_addr == 32'h20) || (ir_valid && ir_pc == 32'h20)) saw20 <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    redirect   = 1'b0;
    redirect_b = 1'b0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_pc   [4];
    logic [31:0] exp_ir   [4];
    logic [31:0] exp_pc_b [4];
    logic [31:0] exp_ir_b [4];
    exp_pc   = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_ir   = '{32'h001F_0018, 32'h002F_0010, 32'h003F_0014, 32'h1322_1000};
    exp_pc_b = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    exp_ir_b = '{32'h5FFF_FFF8, 32'h5FFF_FFFC, 32'hA000_0000, 32'hA000_0004};

    checks        = 0;
    errors        = 0;
    mem_lat       = 0;
    ir_ready      = 1'b1;
    ir_ready_b    = 1'b1;
    redirect      = 1'b0;
    redirect_pc   = '0;
    redirect_b    = 1'b0;
    redirect_pc_b = '0;

    // Reset state
    reset = 1'b1;
    repeat (3) step();
    check("rst_m_req", {31'b0, m_req}, 32'd0);
    check("rst_m_addr", m_addr, 32'h0);
    check("rst_ir_valid", {31'b0, ir_valid}, 32'd0);
    check("rst_ir", ir, 32'h0);
    check("rst_ir_pc", ir_pc, 32'h0);
    check("rst_b_m_addr", m_addr_b, 32'hFFFF_FFF8);

    // Zero-wait streaming on both instances
    reset = 1'b0;
    check("t1_c0_m_req", {31'b0, m_req}, 32'd0);
    step();
    check("t1_c1_m_req", {31'b0, m_req}, 32'd1);
    check("t1_c1_m_addr", m_addr, 32'h0);
    check("t1_c1_ir_valid", {31'b0, ir_valid}, 32'd0);
    check("t1_c1_b_m_addr", m_addr_b, 32'hFFFF_FFF8);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t1_valid%0d", i), {31'b0, ir_valid}, 32'd1);
      check($sformatf("t1_pc%0d", i), ir_pc, exp_pc[i]);
      check($sformatf("t1_ir%0d", i), ir, exp_ir[i]);
      check($sformatf("t1_b_pc%0d", i), ir_pc_b, exp_pc_b[i]);
      check($sformatf("t1_b_ir%0d", i), ir_b, exp_ir_b[i]);
    end
    step();
    redirect_b    = 1'b1;
    redirect_pc_b = 32'h13;
    step();
    redirect_b = 1'b0;
    check("t6_b_m_addr", m_addr_b, 32'h10);
    check("t6_b_ir_valid", {31'b0, ir_valid_b}, 32'd0);
    step();
    check("t6_b_ir_pc", ir_pc_b, 32'h10);
    check("t6_b_ir", ir_b, 32'hA000_0010);

    // Backpressure fills the FIFO, then drains in order
    ir_ready = 1'b0;
    apply_reset();
    repeat (20) step();
    check("t2_acks", 32'(ack_cnt), 32'd4);
    check("t2_m_req", {31'b0, m_req}, 32'd0);
    check("t2_count", 32'(dut.u_fifo.count_o), 32'd4);
    check("t2_head_pc", ir_pc, 32'h0);
    ir_ready = 1'b1;
    step();
    check("t2_pc4", ir_pc, 32'h4);
    check("t2_resume_req", {31'b0, m_req}, 32'd1);
    check("t2_resume_addr", m_addr, 32'h10);
    step();
    check("t2_pc8", ir_pc, 32'h8);
    step();
    check("t2_pcC", ir_pc, 32'hC);
    step();
    check("t2_pc10", ir_pc, 32'h10);
    check("t2_ir10", ir, 32'hA000_0010);

    // Slow memory, redirect while the 0x14 request is pending
    mem_lat  = 3;
    ir_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 100; i++) begin
      if (m_req && m_addr == 32'h14) break;
      step();
    end
    check("t3_reach_14", m_addr, 32'h14);
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0C;
    step();
    redirect = 1'b0;
    check("t3_flush_valid", {31'b0, ir_valid}, 32'd0);
    check("t3_hold_addr", m_addr, 32'h14);
    for (int i = 0; i < 50; i++) begin
      if (ir_valid) break;
      step();
    end
    check("t3_first_pc", ir_pc, 32'h0C);
    check("t3_first_ir", ir, 32'h1322_1000);

    // Redirect together with ack and pop
    mem_lat = 0;
    apply_reset();
    repeat (3) step();
    check("t4_pre_valid", {31'b0, ir_valid}, 32'd1);
    check("t4_pre_ack", {31'b0, m_ack}, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h30;
    step();
    redirect = 1'b0;
    check("t4_valid", {31'b0, ir_valid}, 32'd0);
    check("t4_m_addr", m_addr, 32'h30);
    check("t4_m_req", {31'b0, m_req}, 32'd1);
    step();
    check("t4_pc", ir_pc, 32'h30);
    check("t4_ir", ir, 32'hA000_0030);

    // Two redirects during one pending request: latest wins
    mem_lat = 3;
    apply_reset();
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h20;
    step();
    redirect = 1'b0;
    check("t5_hold_addr", m_addr, 32'h0);
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    step();
    check("t5_m_addr", m_addr, 32'h40);
    check("t5_m_req", {31'b0, m_req}, 32'd1);
    for (int i = 0; i < 50; i++) begin
      if (ir_valid) break;
      step();
    end
    check("t5_pc", ir_pc, 32'h40);
    check("t5_ir", ir, 32'hA000_0040);
    repeat (10) step();
    check("t5_no_20", {31'b0, saw20}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
